// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader
//
// Serial program loader. Receives framed bytes and writes them into program
// memory while holding the CPU in reset.
//
// Frame: SYNC_BYTE, ADDR_HI, ADDR_LO, LEN (0 = 256), LEN data bytes,
//        then a CHK byte when LOADER_CHECKSUM_EN is defined.
//
// Build option:
//   LOADER_CHECKSUM_EN - when defined, an 8-bit running sum of the data bytes
//                        is kept and a trailing CHK byte must make
//                        (sum + CHK) mod 256 == 0. A bad CHK ends the frame in
//                        ERR and sets the sticky error flag. When undefined,
//                        there is no CHK byte and error is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   in_data holds a byte
//   in_data    in   [7:0] loader byte stream
//   in_ready   out  loader can accept a byte (transfer = in_valid & in_ready)
//   mem_addr   out  [ADDR_W-1:0] program memory write address
//   mem_data   out  [7:0] write data (instruction [7:4], operand [3:0])
//   mem_we     out  one-cycle write strobe
//   cpu_hold   out  CPU held in reset while a frame is in progress
//   done       out  one-cycle pulse on successful frame completion
//   error      out  sticky failed-frame flag
//   dbg_state  out  [3:0] current FSM state encoding
//
// Handshake: a byte is consumed on every rising edge where in_valid and
// in_ready are both high; in_ready depends only on the current state, never
// on in_valid, and in_valid low leaves all state untouched.
// ============================================================================
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR_HI = 4'd1,
        S_ADDR_LO = 4'd2,
        S_LEN     = 4'd3,
        S_DATA    = 4'd4,
        S_WRITE   = 4'd5,
        S_CHK     = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    // Nine bits so that LEN=0 can be held as 256.
    logic [8:0]        count_q;
    logic              accept;

    assign accept = in_valid && in_ready;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       err_q;
    logic [7:0] chk_total;

    assign chk_total = sum_q + in_data;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept && in_data == SYNC_BYTE) state_d = S_ADDR_HI;
            S_ADDR_HI: if (accept) state_d = S_ADDR_LO;
            S_ADDR_LO: if (accept) state_d = S_LEN;
            S_LEN:     if (accept) state_d = S_DATA;
            S_DATA:    if (accept) state_d = S_WRITE;
            S_WRITE: begin
                // count_q still holds the pre-decrement value here.
                if (count_q != 9'd1) begin
                    state_d = S_DATA;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) begin
                    state_d = (chk_total == 8'h00) ? S_DONE : S_ERR;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        cpu_hold = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHK: in_ready = 1'b1;
            S_WRITE: mem_we = 1'b1;
            S_DONE:  done   = 1'b1;
            S_ERR:   ;
            default: cpu_hold = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address, write data, remaining count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                // Only ADDR_HI bits [ADDR_W-9:0] survive the truncation.
                S_ADDR_HI: if (accept) addr_q <= ADDR_W'({in_data, 8'h00});
                S_ADDR_LO: if (accept) addr_q[7:0] <= in_data;
                S_LEN:     if (accept) count_q <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                S_DATA:    if (accept) data_q <= in_data;
                S_WRITE: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    count_q <= count_q - 9'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum restarts on every SYNC; error is cleared by the same SYNC
    // and set on the cycle that a bad CHK is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && accept && in_data == SYNC_BYTE) begin
                sum_q <= '0;
                err_q <= 1'b0;
            end else if (state_q == S_DATA && accept) begin
                sum_q <= sum_q + in_data;
            end else if (state_q == S_CHK && accept && chk_total != 8'h00) begin
                err_q <= 1'b1;
            end
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (default ADDR_W=12, SYNC_BYTE=A5).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [3:0]  dbg_state;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int write_cnt = 0;
  int done_cnt = 0;
  int frames_ok = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  payload[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write/done monitor, sampled away from the rising edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      write_cnt++;
      check("write_in_ready_low", 32'(in_ready), 32'd0);
      check("write_hold", 32'(cpu_hold), 32'd1);
      if (exp_q.size() == 0) check("extra_write", 32'(mem_we), 32'd0);
      else check("write_addr_data", {12'h000, mem_addr, mem_data}, 32'(exp_q.pop_front()));
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("done_hold", 32'(cpu_hold), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
  endtask

  // Sends a full frame from payload[], queuing the expected writes first.
  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] len, input int max_gap);
    logic [11:0] a;
    logic [7:0]  sum;
    int          n;
    a   = {hi[3:0], lo};
    sum = 8'h00;
    n   = (len == 8'h00) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, payload[i]});
      a   = a + 12'd1;
      sum = sum + payload[i];
    end
    gap(max_gap); send_byte(8'hA5);
    check("hold_after_sync", 32'(cpu_hold), 32'd1);
    check("error_clear_after_sync", 32'(error), 32'd0);
    gap(max_gap); send_byte(hi);
    gap(max_gap); send_byte(lo);
    gap(max_gap); send_byte(len);
    for (int i = 0; i < n; i++) begin
      gap(max_gap);
      send_byte(payload[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    gap(max_gap); send_byte(8'h00 - sum);
`endif
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 20; i++) begin
      if (done_cnt > d0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("done_pulses", done_cnt - d0, 32'd1);
    check("queue_empty", exp_q.size(), 32'd0);
    check("hold_idle", 32'(cpu_hold), 32'd0);
    check("state_idle", 32'(dbg_state), 32'd0);
    frames_ok++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_data"}, 32'(mem_data), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    int w0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    // Idle noise: non-SYNC bytes are discarded
    send_byte(8'h00);
    send_byte(8'hFF);
    check("noise_state", 32'(dbg_state), 32'd0);
    check("noise_hold", 32'(cpu_hold), 32'd0);
    check("noise_writes", write_cnt, 32'd0);

    // Basic load: 0x010=3C, 0x011=81
    payload = '{8'h3C, 8'h81};
    d0 = done_cnt;
    send_frame(8'h00, 8'h10, 8'h02, 0);
    wait_done(d0);

    // Wrap-around: 0xFFF=11, 0x000=22
    payload = '{8'h11, 8'h22};
    d0 = done_cnt;
    send_frame(8'h0F, 8'hFF, 8'h02, 0);
    wait_done(d0);

    // Upper ADDR_HI bits ignored: F2,34 -> 0x234
    payload = '{8'h5A};
    d0 = done_cnt;
    send_frame(8'hF2, 8'h34, 8'h01, 0);
    wait_done(d0);

    // Stalls: in_valid low holds state, same writes as the basic load
    exp_q.push_back({12'h010, 8'h3C});
    exp_q.push_back({12'h011, 8'h81});
    d0 = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    repeat (5) @(negedge clk);
    check("stall_addr_lo_state", 32'(dbg_state), 32'd2);
    send_byte(8'h10);
    send_byte(8'h02);
    repeat (4) @(negedge clk);
    check("stall_data_state", 32'(dbg_state), 32'd4);
    send_byte(8'h3C);
    repeat (3) @(negedge clk);
    check("stall_data_state2", 32'(dbg_state), 32'd4);
    check("stall_next_addr", 32'(mem_addr), 32'h011);
    send_byte(8'h81);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h43);
`endif
    wait_done(d0);

    // Random-gap stalls on another frame
    payload = '{8'h01, 8'h23, 8'h45};
    d0 = done_cnt;
    send_frame(8'h03, 8'h00, 8'h03, 3);
    wait_done(d0);

    // Reset mid-frame after the first data byte of a 4-byte frame
    exp_q.push_back({12'h020, 8'hD1});
    w0 = write_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h04);
    send_byte(8'hD1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset_writes", write_cnt - w0, 32'd1);
    check("midreset_queue", exp_q.size(), 32'd0);
    check("midreset_idle", 32'(dbg_state), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: one write, error set, no done; next SYNC clears error
    exp_q.push_back({12'h000, 8'h05});
    d0 = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h00);
    check("bad_chk_err_state", 32'(dbg_state), 32'd8);
    check("bad_chk_error", 32'(error), 32'd1);
    repeat (3) @(negedge clk);
    check("bad_chk_error_sticky", 32'(error), 32'd1);
    check("bad_chk_no_done", done_cnt - d0, 32'd0);
    check("bad_chk_queue", exp_q.size(), 32'd0);
    check("bad_chk_hold_idle", 32'(cpu_hold), 32'd0);
    exp_q.push_back({12'h000, 8'h07});
    send_byte(8'hA5);
    check("sync_clears_error", 32'(error), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h07);
    send_byte(8'hF9);
    wait_done(d0);
`else
    check("error_tied_low", 32'(error), 32'd0);
`endif

    // LEN=0: 256 writes from 0xF80 wrapping to 0x07F
    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(8'(i));
    w0 = write_cnt;
    d0 = done_cnt;
    send_frame(8'h0F, 8'h80, 8'h00, 0);
    wait_done(d0);
    check("len0_write_count", write_cnt - w0, 32'd256);
    check("len0_final_addr", 32'(mem_addr), 32'h080);

    check("total_done", done_cnt, frames_ok);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
